// File: rtl/aes_decrypt_core.sv
// Iterative AES inverse cipher, one round per clock; done pulses NR clocks after the start edge.
// No backpressure: start is ignored while busy and plaintext holds until the next done.

module aes_inv_shiftrows (
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            // Row r rotates right by r columns; byte index is 4*col+row.
            assign state_o[127-8*(4*c+r) -: 8] = state_i[127-8*(4*((c+4-r)%4)+r) -: 8];
        end
    end
endmodule

module aes_inv_subbytes (
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = 11'd2047 - {b, 3'b000};
        return INV_SBOX[idx -: 8];
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign state_o[127-8*i -: 8] = inv_sbox(state_i[127-8*i -: 8]);
    end
endmodule

module aes_inv_mixcolumns (
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant (0x09/0x0b/0x0d/0x0e).
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] x2, x4, x8;
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        return ({8{m[0]}} & a) ^ ({8{m[1]}} & x2) ^ ({8{m[2]}} & x4) ^ ({8{m[3]}} & x8);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = state_i[127-32*c -: 8];
        assign a1 = state_i[119-32*c -: 8];
        assign a2 = state_i[111-32*c -: 8];
        assign a3 = state_i[103-32*c -: 8];
        assign state_o[127-32*c -: 8] = gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9);
        assign state_o[119-32*c -: 8] = gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd);
        assign state_o[111-32*c -: 8] = gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb);
        assign state_o[103-32*c -: 8] = gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he);
    end
endmodule

module aes_decrypt_core #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] ciphertext,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         busy,
    output logic         done,
    output logic [127:0] plaintext
);
    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
        $error("aes_decrypt_core: NR must be 10, 12 or 14");
    end

    localparam logic [3:0] NR_IDX = 4'(NR);
    localparam logic [3:0] NR_M1  = 4'(NR - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e       fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] pt_q, pt_d;
    logic         done_q, done_d;

    logic [127:0] isr, isb, t, imc;

    aes_inv_shiftrows  u_isr (.state_i(blk_q), .state_o(isr));
    aes_inv_subbytes   u_isb (.state_i(isr),   .state_o(isb));
    assign t = isb ^ rk_data;
    aes_inv_mixcolumns u_imc (.state_i(t),     .state_o(imc));

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        blk_d   = blk_q;
        pt_d    = pt_q;
        done_d  = 1'b0;
        rk_idx  = NR_IDX;
        busy    = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    blk_d   = ciphertext ^ rk_data;
                    round_d = NR_M1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                rk_idx = round_q;
                busy   = 1'b1;
                if (round_q != 4'd0) begin
                    blk_d   = imc;
                    round_d = round_q - 4'd1;
                end else begin
                    // Final round skips InvMixColumns.
                    pt_d   = t;
                    done_d = 1'b1;
                    fsm_d  = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            round_q <= 4'd0;
            blk_q   <= '0;
            pt_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            blk_q   <= blk_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
        end
    end

    assign done      = done_q;
    assign plaintext = pt_q;
endmodule

// File: tb/tb_aes_decrypt_core.sv
// Scoreboard bench for aes_decrypt_core: NR=10 and NR=14 instances fed from bench-expanded key stores.
module tb_aes_decrypt_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         start10 = 1'b0, start14 = 1'b0;
    logic [127:0] ct10 = '0, ct14 = '0;
    logic [3:0]   rk_idx10, rk_idx14;
    logic [127:0] rk10, rk14, pt10, pt14;
    logic         busy10, busy14, done10, done14;

    logic [127:0] ks10 [0:15];
    logic [127:0] ks14 [0:15];
    assign rk10 = ks10[rk_idx10];
    assign rk14 = ks14[rk_idx14];

    aes_decrypt_core #(.NR(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start10), .ciphertext(ct10),
        .rk_idx(rk_idx10), .rk_data(rk10), .busy(busy10), .done(done10), .plaintext(pt10)
    );
    aes_decrypt_core #(.NR(14)) dut14 (
        .clk(clk), .rst_n(rst_n), .start(start14), .ciphertext(ct14),
        .rk_idx(rk_idx14), .rk_data(rk14), .busy(busy14), .done(done14), .plaintext(pt14)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    // Forward S-box derived from GF(2^8) inversion plus the affine map, for key expansion only.
    logic [7:0] sbox [0:255];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        logic [31:0] o;
        for (int b = 0; b < 4; b++) o[31-8*b -: 8] = sbox[w[31-8*b -: 8]];
        return o;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [255:0] key, input int nk, input int nr, input int sel);
        logic [31:0] w [0:59];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subword(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r <= nr; r++) begin
            if (sel == 0) ks10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else          ks14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    typedef struct {
        logic [127:0] pt;
        int           due;
    } exp_t;
    exp_t q10[$];
    exp_t q14[$];
    exp_t e10, e14;

    always @(negedge clk) begin
        if (done10) begin
            if (q10.size() == 0) check_eq("dut10 spurious done", 128'd1, 128'd0);
            else begin
                e10 = q10.pop_front();
                check_eq("dut10 plaintext", pt10, e10.pt);
                check_eq("dut10 done cycle", 128'(cyc), 128'(e10.due));
            end
        end
        if (done14) begin
            if (q14.size() == 0) check_eq("dut14 spurious done", 128'd1, 128'd0);
            else begin
                e14 = q14.pop_front();
                check_eq("dut14 plaintext", pt14, e14.pt);
                check_eq("dut14 done cycle", 128'(cyc), 128'(e14.due));
            end
        end
    end

    // Called #1 after a posedge; start is sampled on the next edge.
    task automatic launch(input int sel, input logic [127:0] ct, input logic [127:0] pt,
                          input bit push, input bit chk_idx);
        int   nr;
        exp_t e;
        nr    = (sel == 0) ? 10 : 14;
        e.pt  = pt;
        e.due = cyc + 1 + nr;
        if (push) begin
            if (sel == 0) q10.push_back(e);
            else          q14.push_back(e);
        end
        if (sel == 0) begin start10 = 1'b1; ct10 = ct; end
        else          begin start14 = 1'b1; ct14 = ct; end
        if (chk_idx) check_eq("rk_idx at start", 128'((sel == 0) ? rk_idx10 : rk_idx14), 128'(nr));
        @(posedge clk); #1;
        start10 = 1'b0;
        start14 = 1'b0;
        if (sel == 0) ct10 = {4{$urandom()}};
        else          ct14 = {4{$urandom()}};
        if (chk_idx) begin
            for (int i = nr - 1; i >= 0; i--) begin
                check_eq("rk_idx in run", 128'((sel == 0) ? rk_idx10 : rk_idx14), 128'(i));
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q10.size() != 0 || q14.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q10.size() != 0 || q14.size() != 0)
            check_eq("drain timeout", 128'(q10.size() + q14.size()), 128'd0);
        @(posedge clk); #1;
    endtask

    localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;

    initial begin
        int n;
        for (int i = 0; i < 16; i++) begin ks10[i] = '0; ks14[i] = '0; end
        build_sbox();

        // Reset values.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset busy10", 128'(busy10), 128'd0);
        check_eq("reset done10", 128'(done10), 128'd0);
        check_eq("reset pt10", pt10, 128'd0);
        check_eq("reset rk_idx10", 128'(rk_idx10), 128'd10);
        check_eq("reset rk_idx14", 128'(rk_idx14), 128'd14);
        check_eq("reset pt14", pt14, 128'd0);
        rst_n = 1'b1;

        // Idle with start low.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check_eq("idle busy", 128'(busy10), 128'd0);
            check_eq("idle done", 128'(done10), 128'd0);
            check_eq("idle plaintext", pt10, 128'd0);
        end

        // FIPS-197 App. B and C.1 on NR=10, C.3 on NR=14.
        expand({KEY_B, 128'h0}, 4, 10, 0);
        launch(0, CT_B, PT_B, 1'b1, 1'b1);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check_eq("plaintext hold", pt10, PT_B);

        expand({KEY_C1, 128'h0}, 4, 10, 0);
        launch(0, CT_C1, PT_C, 1'b1, 1'b1);
        drain();

        expand(KEY_C3, 8, 14, 1);
        launch(1, CT_C3, PT_C, 1'b1, 1'b1);
        drain();

        // Start and ciphertext change mid-block are ignored; start during done is accepted.
        expand({KEY_B, 128'h0}, 4, 10, 0);
        launch(0, CT_B, PT_B, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        start10 = 1'b1;
        ct10    = {4{$urandom()}};
        @(posedge clk); #1;
        start10 = 1'b0;
        check_eq("busy after ignored start", 128'(busy10), 128'd1);
        n = 0;
        while (!done10 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("first done seen", 128'(done10), 128'd1);
        expand({KEY_C1, 128'h0}, 4, 10, 0);
        launch(0, CT_C1, PT_C, 1'b1, 1'b0);
        drain();

        // Start held high: a new block every NR+1 cycles.
        expand({KEY_B, 128'h0}, 4, 10, 0);
        e10.pt  = PT_B;
        e10.due = cyc + 11;
        q10.push_back(e10);
        e10.due = cyc + 22;
        q10.push_back(e10);
        start10 = 1'b1;
        ct10    = CT_B;
        repeat (12) @(posedge clk);
        #1;
        start10 = 1'b0;
        drain();

        // Reset in RUN cycle 5 abandons the block.
        launch(0, CT_B, PT_B, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("midreset busy", 128'(busy10), 128'd0);
        check_eq("midreset done", 128'(done10), 128'd0);
        check_eq("midreset plaintext", pt10, 128'd0);
        check_eq("midreset rk_idx", 128'(rk_idx10), 128'd10);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check_eq("no done after reset", pt10, 128'd0);
        launch(0, CT_B, PT_B, 1'b1, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
